// File: rtl/masked_gf_mul_pkg.sv
// masked_gf_mul_pkg: shared types and helpers for the
// DOM-indep masked GF(2^n) multiplier.
package masked_gf_mul_pkg;

  localparam int unsigned MAX_BW = 4;
  localparam int unsigned MAX_S  = 4;

  // Number of fresh mask words for s shares.
  function automatic int unsigned num_rand(
    input int unsigned s
  );
    return s * (s - 1) / 2;
  endfunction

  // Lexicographic index of the unordered pair {i,j}, i != j.
  function automatic int unsigned pair_idx(
    input int unsigned i,
    input int unsigned j,
    input int unsigned s
  );
    int unsigned lo;
    int unsigned hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * (2 * s - lo - 1) / 2 + (hi - lo - 1);
  endfunction

  // Low coefficients of the reduction polynomial:
  // GF(2): x+1, GF(4): x^2+x+1, GF(16): x^4+x+1.
  function automatic logic [MAX_BW-1:0] field_poly(
    input int unsigned bw
  );
    logic [MAX_BW-1:0] p;
    p = 4'h3;
    if (bw == 1) p = 4'h1;
    return p;
  endfunction

  typedef logic [MAX_BW-1:0]         gf_elem_t;
  typedef logic [MAX_S*MAX_BW-1:0]   share_vec_t;
  typedef logic [num_rand(MAX_S)*MAX_BW-1:0] rand_vec_t;

endpackage

// File: rtl/masked_gf_mul_field.sv
// masked_gf_mul_field: unmasked GF(2^n) multiplier,
// polynomial basis, MSB-first shift-and-reduce.
module masked_gf_mul_field
  import masked_gf_mul_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 2
) (
  input  logic [BIT_WIDTH-1:0] a_i,
  input  logic [BIT_WIDTH-1:0] b_i,
  output logic [BIT_WIDTH-1:0] p_o
);

  localparam logic [BIT_WIDTH-1:0] POLY =
    BIT_WIDTH'(field_poly(BIT_WIDTH));

  logic [BIT_WIDTH-1:0] acc;

  // Horner evaluation over the bits of b, reducing each step
  always_comb begin
    acc = '0;
    for (int i = int'(BIT_WIDTH) - 1; i >= 0; i--) begin
      acc = (acc << 1) ^ (acc[BIT_WIDTH-1] ? POLY : '0);
      if (b_i[i]) acc = acc ^ a_i;
    end
    p_o = acc;
  end

endmodule

// File: rtl/masked_gf_mul.sv
// masked_gf_mul: pipelined DOM-indep masked multiplier
// over GF(2^BIT_WIDTH) with NUM_SHARES shares.
module masked_gf_mul
  import masked_gf_mul_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 2,
  parameter int unsigned NUM_SHARES = 2,
  parameter bit          OUTPUT_REG = 1'b1
) (
  input  logic in_clock,
  input  logic in_reset,
  input  logic in_valid,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0] in_a,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0] in_b,
  input  logic [num_rand(NUM_SHARES)*BIT_WIDTH-1:0]
               in_random,
  output logic [NUM_SHARES*BIT_WIDTH-1:0] out_c,
  output logic out_valid
);

  localparam int S  = int'(NUM_SHARES);
  localparam int BW = int'(BIT_WIDTH);
  localparam int NT = S * S;

  typedef logic [S*BW-1:0]  share_t;
  typedef logic [NT*BW-1:0] term_t;

  if (!(BW == 1 || BW == 2 || BW == 4)) begin : g_bad_bw
    $error("masked_gf_mul: BIT_WIDTH must be 1, 2 or 4");
  end
  if (S < 2 || S > 4) begin : g_bad_s
    $error("masked_gf_mul: NUM_SHARES must be 2..4");
  end

  term_t  prod;
  term_t  t_d;
  term_t  t_q;
  share_t c_d;
  logic   v1_q;

  for (genvar gi = 0; gi < S; gi++) begin : g_row
    for (genvar gj = 0; gj < S; gj++) begin : g_col
      localparam int TI = (gi * S + gj) * BW;

      masked_gf_mul_field #(
        .BIT_WIDTH(BIT_WIDTH)
      ) u_mul (
        .a_i(in_a[gi*BW +: BW]),
        .b_i(in_b[gj*BW +: BW]),
        .p_o(prod[TI +: BW])
      );

      if (gi == gj) begin : g_inner
        assign t_d[TI +: BW] = prod[TI +: BW];
      end else begin : g_cross
        localparam int K = int'(pair_idx(gi, gj, S));
        assign t_d[TI +: BW] =
          prod[TI +: BW] ^ in_random[K*BW +: BW];
      end
    end
  end

  // Term register: captures all S^2 terms on qualified input only
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      t_q <= '0;
    end else if (in_valid) begin
      t_q <= t_d;
    end
  end

  // First flop of the valid chain
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= in_valid;
    end
  end

  // Compression: share i folds its own row of terms
  always_comb begin
    c_d = '0;
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) begin
        c_d[i*BW +: BW] =
          c_d[i*BW +: BW] ^ t_q[(i*S+j)*BW +: BW];
      end
    end
  end

  if (OUTPUT_REG) begin : g_oreg
    share_t c_q;
    logic   v2_q;

    // Output register advances only behind a valid term set
    always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
        c_q  <= '0;
        v2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) c_q <= c_d;
      end
    end

    assign out_c     = c_q;
    assign out_valid = v2_q;
  end else begin : g_comb
    assign out_c     = c_d;
    assign out_valid = v1_q;
  end

endmodule

// File: tb/tb_masked_gf_mul.sv
// tb_masked_gf_mul: three masked multiplier configurations
// driven randomly and checked against a share-level model.
module tb_masked_gf_mul;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        vld [ND];
  logic [15:0] av  [ND];
  logic [15:0] bv  [ND];
  logic [23:0] rv  [ND];

  logic [1:0] c0;
  logic [5:0] c1;
  logic [7:0] c2;
  logic ov0, ov1, ov2;

  int vectors = 0;
  int miscompares = 0;

  // dut0: GF(2), 2 shares, registered output
  masked_gf_mul #(
    .BIT_WIDTH(1), .NUM_SHARES(2), .OUTPUT_REG(1'b1)
  ) u0 (
    .in_clock(clk), .in_reset(rst), .in_valid(vld[0]),
    .in_a(av[0][1:0]), .in_b(bv[0][1:0]),
    .in_random(rv[0][0:0]),
    .out_c(c0), .out_valid(ov0)
  );

  // dut1: GF(4), 3 shares, registered output
  masked_gf_mul #(
    .BIT_WIDTH(2), .NUM_SHARES(3), .OUTPUT_REG(1'b1)
  ) u1 (
    .in_clock(clk), .in_reset(rst), .in_valid(vld[1]),
    .in_a(av[1][5:0]), .in_b(bv[1][5:0]),
    .in_random(rv[1][5:0]),
    .out_c(c1), .out_valid(ov1)
  );

  // dut2: GF(16), 2 shares, combinational output
  masked_gf_mul #(
    .BIT_WIDTH(4), .NUM_SHARES(2), .OUTPUT_REG(1'b0)
  ) u2 (
    .in_clock(clk), .in_reset(rst), .in_valid(vld[2]),
    .in_a(av[2][7:0]), .in_b(bv[2][7:0]),
    .in_random(rv[2][3:0]),
    .out_c(c2), .out_valid(ov2)
  );

  function automatic int bw_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  function automatic int s_of(input int d);
    return (d == 1) ? 3 : 2;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 2) ? 1 : 2;
  endfunction

  function automatic logic [15:0] get_c(input int d);
    if (d == 0) return {14'b0, c0};
    if (d == 1) return {10'b0, c1};
    return {8'b0, c2};
  endfunction

  function automatic logic get_v(input int d);
    if (d == 0) return ov0;
    if (d == 1) return ov1;
    return ov2;
  endfunction

  function automatic logic [3:0] fld(
    input logic [23:0] v, input int k, input int bw
  );
    logic [23:0] m;
    m = (24'd1 << bw) - 24'd1;
    return 4'((v >> (k * bw)) & m);
  endfunction

  // Field product: carry-less multiply, then reduce
  function automatic logic [3:0] gfm(
    input logic [3:0] x, input logic [3:0] y,
    input int bw
  );
    logic [7:0] p;
    logic [7:0] pl;
    p  = 8'h00;
    pl = (bw == 1) ? 8'h03 : (bw == 2) ? 8'h07 : 8'h13;
    for (int i = 0; i < bw; i++)
      if (y[i]) p = p ^ (8'(x) << i);
    for (int k = 2 * bw - 2; k >= bw; k--)
      if (p[k]) p = p ^ (pl << (k - bw));
    return p[3:0];
  endfunction

  function automatic int pidx(
    input int i, input int j, input int s
  );
    int k;
    int lo;
    int hi;
    k  = 0;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    for (int p = 0; p < s; p++)
      for (int q = p + 1; q < s; q++) begin
        if (p == lo && q == hi) return k;
        k++;
      end
    return -1;
  endfunction

  function automatic logic [3:0] xor_sh(
    input logic [23:0] v, input int bw, input int s
  );
    logic [3:0] x;
    x = 4'h0;
    for (int i = 0; i < s; i++) x = x ^ fld(v, i, bw);
    return x;
  endfunction

  // Expected output shares straight from the DOM equations
  function automatic logic [15:0] model_c(
    input logic [23:0] a, input logic [23:0] b,
    input logic [23:0] r, input int bw, input int s
  );
    logic [15:0] c;
    logic [3:0]  ci;
    c = 16'h0;
    for (int i = 0; i < s; i++) begin
      ci = gfm(fld(a, i, bw), fld(b, i, bw), bw);
      for (int j = 0; j < s; j++)
        if (j != i)
          ci = ci ^ gfm(fld(a, i, bw), fld(b, j, bw), bw)
                  ^ fld(r, pidx(i, j, s), bw);
      c = c | (16'(ci) << (i * bw));
    end
    return c;
  endfunction

  function automatic logic [3:0] model_p(input int d);
    return gfm(xor_sh(24'(av[d]), bw_of(d), s_of(d)),
               xor_sh(24'(bv[d]), bw_of(d), s_of(d)),
               bw_of(d));
  endfunction

  function automatic logic [15:0] model_s(input int d);
    return model_c(24'(av[d]), 24'(bv[d]), rv[d],
                   bw_of(d), s_of(d));
  endfunction

  task automatic chk(
    input string nm, input int d,
    input logic [23:0] got, input logic [23:0] exp
  );
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d got=%h expected=%h t=%0t",
               nm, d, got, exp, $time);
    end
  endtask

  logic        pv0 [ND];
  logic [15:0] pc0 [ND];
  logic [3:0]  pp0 [ND];
  logic        ev  [ND];
  logic [15:0] ec  [ND];
  logic [3:0]  ep  [ND];

  // Model: in-flight operation plus last delivered result
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        pv0[d] <= 1'b0;
        pc0[d] <= '0;
        pp0[d] <= '0;
        ev[d]  <= 1'b0;
        ec[d]  <= '0;
        ep[d]  <= '0;
      end else if (lat_of(d) == 2) begin
        ev[d]  <= pv0[d];
        if (pv0[d]) begin
          ec[d] <= pc0[d];
          ep[d] <= pp0[d];
        end
        pv0[d] <= vld[d];
        if (vld[d]) begin
          pc0[d] <= model_s(d);
          pp0[d] <= model_p(d);
        end
      end else begin
        ev[d] <= vld[d];
        if (vld[d]) begin
          ec[d] <= model_s(d);
          ep[d] <= model_p(d);
        end
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      chk("out_valid", d, 24'(get_v(d)), 24'(ev[d]));
      chk("out_c", d, 24'(get_c(d)), 24'(ec[d]));
      if (ev[d])
        chk("xor_c", d,
            24'(xor_sh(24'(get_c(d)), bw_of(d), s_of(d))),
            24'(ep[d]));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rand_in(input int d, input logic v);
    vld[d] = v;
    av[d]  = 16'($urandom);
    bv[d]  = 16'($urandom);
    rv[d]  = 24'($urandom);
  endtask

  task automatic idle_all();
    for (int d = 0; d < ND; d++) vld[d] = 1'b0;
  endtask

  initial begin : stim
    logic [3:0]  pat;
    logic [15:0] prevc;
    logic [15:0] seen;
    logic [17:0] hold_t;
    logic [15:0] hold_c;
    int nv;
    int guard;

    for (int d = 0; d < ND; d++) begin
      vld[d] = 1'b0;
      av[d]  = '0;
      bv[d]  = '0;
      rv[d]  = '0;
    end
    #1 rst = 1'b1;
    cyc();
    for (int d = 0; d < ND; d++) begin
      chk("rst0_v", d, 24'(get_v(d)), 24'h0);
      chk("rst0_c", d, 24'(get_c(d)), 24'h0);
    end
    cyc();
    rst = 1'b0;
    cyc();

    // GF(2) hand case: c = (1,1), two-cycle latency
    vld[0] = 1'b1;
    av[0] = 16'h1;
    bv[0] = 16'h3;
    rv[0] = 24'h1;
    cyc();
    vld[0] = 1'b0;
    chk("lat_early", 0, 24'(ov0), 24'h0);
    cyc();
    chk("lat_v", 0, 24'(ov0), 24'h1);
    chk("hand_c", 0, 24'(c0), 24'h3);
    cyc();
    chk("lat_late", 0, 24'(ov0), 24'h0);
    chk("hand_hold", 0, 24'(c0), 24'h3);

    // GF(16) hand case: 2*9 = 1, r = 5 -> c = (4,5)
    vld[2] = 1'b1;
    av[2] = 16'h02;
    bv[2] = 16'h09;
    rv[2] = 24'h5;
    cyc();
    vld[2] = 1'b0;
    chk("hand16_v", 2, 24'(ov2), 24'h1);
    chk("hand16_c", 2, 24'(c2), 24'h54);
    cyc();
    chk("hand16_v0", 2, 24'(ov2), 24'h0);
    chk("hand16_hold", 2, 24'(c2), 24'h54);

    // Valid pattern 1,1,0,1 through the latency-1 build
    pat = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      prevc = get_c(2);
      rand_in(2, pat[k]);
      cyc();
      chk("pat_v", 2, 24'(ov2), 24'(pat[k]));
      if (!pat[k])
        chk("pat_hold", 2, 24'(get_c(2)), 24'(prevc));
    end
    idle_all();
    cyc();

    // Fixed operands, mask word swept 0..F
    seen = '0;
    for (int r = 0; r < 16; r++) begin
      vld[2] = 1'b1;
      av[2] = 16'h7B;
      bv[2] = 16'hC5;
      rv[2] = 24'(r);
      cyc();
      seen = seen | (16'h1 << c2[3:0]);
    end
    idle_all();
    chk("rdep", 2, 24'($countones(seen)), 24'd16);
    cyc();

    // Asynchronous reset with operations in flight
    for (int d = 0; d < ND; d++) rand_in(d, 1'b1);
    cyc();
    for (int d = 0; d < ND; d++) rand_in(d, 1'b1);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("arst_v", d, 24'(get_v(d)), 24'h0);
      chk("arst_c", d, 24'(get_c(d)), 24'h0);
    end
    cyc();
    cyc();
    rst = 1'b0;
    for (int d = 0; d < ND; d++) rand_in(d, 1'b1);
    cyc();
    idle_all();
    repeat (3) cyc();

    // Hold: unqualified toggling inputs must not move state
    rand_in(1, 1'b1);
    cyc();
    vld[1] = 1'b0;
    cyc();
    hold_t = u1.t_q;
    hold_c = get_c(1);
    for (int k = 0; k < 6; k++) begin
      rand_in(1, 1'b0);
      cyc();
      chk("hold_t", 1, 24'(u1.t_q), 24'(hold_t));
      chk("hold_c", 1, 24'(get_c(1)), 24'(hold_c));
    end

    // Random sweep: 10k valid operations on the 3-share build
    nv = 0;
    guard = 0;
    while (nv < 10000 && guard < 20000) begin
      for (int d = 0; d < ND; d++)
        rand_in(d, logic'($urandom_range(0, 7) != 0));
      if (vld[1]) nv++;
      cyc();
      guard++;
    end
    chk("sweep_n", 1, 24'(nv), 24'd10000);

    idle_all();
    repeat (4) cyc();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
